frame_buffer_dbl: RTL

//  Double-buffered, parametrised frame buffer between sprite/background renderers and the VGA colour mapper.

---
 rtl/frame_buffer_dbl_pkg.sv | 22 ++
 rtl/frame_buffer_dbl_if.sv | 14 +
 rtl/frame_buffer_dbl_ram.sv | 23 ++
 rtl/frame_buffer_dbl.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/frame_buffer_dbl_pkg.sv
// Shared types and address helper for the double-buffered frame buffer.
// Pixel addresses are page-major: page 1 starts right after page 0's last pixel.
package frame_buffer_dbl_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        CLEAR     = 2'd1,
        SWAP_PEND = 2'd2
    } fb_state_t;

    // Intermediate products are kept at 32 bits; the caller truncates to RAM width.
    function automatic logic [31:0] fb_addr(input logic        page,
                                            input logic [31:0] x,
                                            input logic [31:0] y,
                                            input int          h_res,
                                            input int          v_res);
        logic [31:0] base;
        base = page ? 32'(h_res * v_res) : 32'd0;
        return base + y * 32'(h_res) + x;
    endfunction

endpackage

// File: rtl/frame_buffer_dbl_if.sv
// Renderer write port. Handshake: a write transfers on any clock edge where
// wr_valid && wr_ready; the master holds x/y/pix stable while wr_valid is high.
interface frame_buffer_dbl_if #(
    parameter int PIX_W = 5
);
    logic             wr_valid;
    logic             wr_ready;
    logic [9:0]       wr_x;
    logic [9:0]       wr_y;
    logic [PIX_W-1:0] wr_pix;

    modport master (output wr_valid, output wr_x, output wr_y, output wr_pix, input wr_ready);
    modport slave  (input wr_valid, input wr_x, input wr_y, input wr_pix, output wr_ready);
endinterface

// File: rtl/frame_buffer_dbl_ram.sv
// Simple dual-port RAM: one write port, one registered read port, no reset
// so it maps onto block RAM.
module frame_buffer_dbl_ram #(
    parameter int DEPTH = 614400,
    parameter int WIDTH = 5,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             Clk,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);
    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge Clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_o <= mem_q[raddr_i];
    end
endmodule

// File: rtl/frame_buffer_dbl.sv
// Double-buffered frame buffer: display reads the front page, renderers and the
// clear engine write the back page, page swap happens only on frame_start.
module frame_buffer_dbl
    import frame_buffer_dbl_pkg::*;
#(
    parameter int               H_RES     = 640,
    parameter int               V_RES     = 480,
    parameter int               PIX_W     = 5,
    parameter logic [PIX_W-1:0] KEY_COLOR = 5'h15,
    parameter logic [PIX_W-1:0] CLR_COLOR = 5'h00
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               frame_start,
    input  logic [9:0]         DrawX,
    input  logic [9:0]         DrawY,
    output logic [PIX_W-1:0]   pixelOut,
    frame_buffer_dbl_if.slave  wr,
    input  logic               clear_req,
    input  logic               swap_req,
    output logic               swap_done,
    output logic               front_page,
    output logic               busy,
    output logic [1:0]         dbg_state
);
    localparam int NPIX  = H_RES * V_RES;
    localparam int DEPTH = 2 * NPIX;
    localparam int AW    = $clog2(DEPTH);
    localparam int CW    = $clog2(NPIX);

    localparam logic [1:0] ST_IDLE      = 2'(IDLE);
    localparam logic [1:0] ST_CLEAR     = 2'(CLEAR);
    localparam logic [1:0] ST_SWAP_PEND = 2'(SWAP_PEND);

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    clr_cnt_q, clr_cnt_d;
    logic             swap_lat_q, swap_lat_d;
    logic             front_q, front_d;
    logic             swap_done_q, swap_done_d;
    logic             rd_ok_q;

    logic             back_page;
    logic             wr_fire;
    logic             wr_in_range;
    logic             rd_in_range;
    logic             ram_we;
    logic [AW-1:0]    ram_waddr;
    logic [PIX_W-1:0] ram_wdata;
    logic [AW-1:0]    ram_raddr;
    logic [PIX_W-1:0] ram_rdata;

    assign back_page   = ~front_q;
    assign wr.wr_ready = !Reset && (state_q == ST_IDLE || state_q == ST_SWAP_PEND);
    assign wr_fire     = wr.wr_valid && wr.wr_ready;
    assign wr_in_range = (32'(wr.wr_x) < H_RES) && (32'(wr.wr_y) < V_RES);
    assign rd_in_range = (32'(DrawX) < H_RES) && (32'(DrawY) < V_RES);

    always_comb begin
        state_d     = state_q;
        clr_cnt_d   = clr_cnt_q;
        swap_lat_d  = swap_lat_q;
        front_d     = front_q;
        swap_done_d = 1'b0;
        ram_we      = 1'b0;
        ram_waddr   = '0;
        ram_wdata   = CLR_COLOR;
        case (state_q)
            ST_IDLE: begin
                if (clear_req) begin
                    state_d    = ST_CLEAR;
                    clr_cnt_d  = '0;
                    swap_lat_d = swap_req;
                end else if (swap_req) begin
                    state_d = ST_SWAP_PEND;
                end
            end
            ST_CLEAR: begin
                ram_we    = 1'b1;
                ram_waddr = AW'(fb_addr(back_page, 32'(clr_cnt_q), 32'd0, H_RES, V_RES));
                if (swap_req) begin
                    swap_lat_d = 1'b1;
                end
                if (clr_cnt_q == CW'(NPIX - 1)) begin
                    state_d    = (swap_lat_q || swap_req) ? ST_SWAP_PEND : ST_IDLE;
                    swap_lat_d = 1'b0;
                end else begin
                    clr_cnt_d = clr_cnt_q + CW'(1);
                end
            end
            ST_SWAP_PEND: begin
                if (frame_start) begin
                    state_d     = ST_IDLE;
                    front_d     = ~front_q;
                    swap_done_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Renderer writes never overlap the clear: wr_ready is low in CLEAR.
        if (wr_fire && wr_in_range && wr.wr_pix != KEY_COLOR) begin
            ram_we    = 1'b1;
            ram_waddr = AW'(fb_addr(back_page, 32'(wr.wr_x), 32'(wr.wr_y), H_RES, V_RES));
            ram_wdata = wr.wr_pix;
        end
    end

    assign ram_raddr = rd_in_range ? AW'(fb_addr(front_q, 32'(DrawX), 32'(DrawY), H_RES, V_RES)) : '0;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= ST_IDLE;
            clr_cnt_q   <= '0;
            swap_lat_q  <= 1'b0;
            front_q     <= 1'b0;
            swap_done_q <= 1'b0;
            rd_ok_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            clr_cnt_q   <= clr_cnt_d;
            swap_lat_q  <= swap_lat_d;
            front_q     <= front_d;
            swap_done_q <= swap_done_d;
            rd_ok_q     <= rd_in_range;
        end
    end

    frame_buffer_dbl_ram #(
        .DEPTH (DEPTH),
        .WIDTH (PIX_W)
    ) u_ram (
        .Clk     (Clk),
        .we_i    (ram_we),
        .waddr_i (ram_waddr),
        .wdata_i (ram_wdata),
        .raddr_i (ram_raddr),
        .rdata_o (ram_rdata)
    );

    // swap_done rises together with the new front_page value.
    assign pixelOut   = rd_ok_q ? ram_rdata : '0;
    assign swap_done  = swap_done_q;
    assign front_page = front_q;
    assign busy       = (state_q != ST_IDLE);
    assign dbg_state  = state_q;
endmodule
